// File: rtl/aes_enc_core.sv
// ---------------------------------------------------------------------------
// aes_enc_core
//
// Iterative AES-128 encryption datapath. One plaintext block is accepted per
// valid/ready handshake. The core restarts the external key schedule with
// key_start and advances it with key_step. It consumes one round key per
// round and presents the ciphertext on a valid/ready output.
//
// Ports
//   clk        : single clock, all logic on posedge
//   rst        : synchronous reset, active-high
//   in_valid   : plaintext block offered
//   in_ready   : core idle and able to accept a block
//   in_data    : plaintext, [127:120] = byte 0, column-major (FIPS-197)
//   out_valid  : ciphertext available
//   out_ready  : downstream accepts the ciphertext
//   out_data   : ciphertext, same byte order as in_data
//   key_start  : registered, restarts key schedule at round key 0
//   key_step   : registered, rising edge requests the next round key
//   round_key  : current round key from the key schedule
//   busy       : high in every state except IDLE
//
// Also contains s_box, the AES SubBytes byte substitution, computed as the
// GF(2^8) multiplicative inverse followed by the affine transform.
// ---------------------------------------------------------------------------

module s_box (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] sq;
   logic [7:0] inv;

   // x^254 = x^2 * x^4 * ... * x^128 is the inverse (and maps 0 to 0)
   always_comb begin
      sq  = in_byte;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                     ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

module aes_enc_core #(
   parameter int NUM_ROUNDS = 10,
   parameter int SETTLE     = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         key_start,
   output logic         key_step,
   input  logic [127:0] round_key,
   output logic         busy
);

   localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KSTART,
      ST_ADD0,
      ST_STEP,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [127:0]    data_q, data_d;
   logic [3:0]      round_q, round_d;
   logic [SW-1:0]   settle_q, settle_d;

   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic [127:0]    out_data_q, out_data_d;
   logic            key_start_q, key_start_d;
   logic            key_step_q, key_step_d;
   logic            busy_q, busy_d;

   logic [7:0]      sb_out [16];
   logic [7:0]      sr     [16];
   logic [7:0]      mc     [16];
   logic [127:0]    round_out;
   logic            last_round;
   logic            last_wait;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // SubBytes: one substitution unit per state byte
   for (genvar k = 0; k < 16; k++) begin : g_sbox
      s_box u_sbox (
         .in_byte  (data_q[127-8*k -: 8]),
         .out_byte (sb_out[k])
      );
   end

   assign last_round = (round_q == 4'(NUM_ROUNDS));
   assign last_wait  = (settle_q == SW'(SETTLE - 1));

   // Round datapath: ShiftRows, MixColumns (skipped in the final round),
   // AddRoundKey. Byte k sits at row k%4, column k/4.
   always_comb begin
      for (int k = 0; k < 16; k++) begin
         sr[k] = 8'h00;
         mc[k] = 8'h00;
      end
      round_out = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[r + 4*c] = sb_out[r + 4*((c + r) % 4)];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc[4*c]   = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
         mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
      end
      for (int k = 0; k < 16; k++) begin
         round_out[127-8*k -: 8] = (last_round ? sr[k] : mc[k]) ^ round_key[127-8*k -: 8];
      end
   end

   // State register and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         data_q      <= '0;
         round_q     <= '0;
         settle_q    <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         key_start_q <= 1'b0;
         key_step_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         round_q     <= round_d;
         settle_q    <= settle_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         key_start_q <= key_start_d;
         key_step_q  <= key_step_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state and datapath update. round_key is only consumed in ADD0 and
   // on the last settle cycle of WAIT, after key_step has been low long
   // enough for the schedule to present the new key.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      round_d  = round_q;
      settle_d = settle_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               state_d = ST_KSTART;
            end
         end
         ST_KSTART: begin
            state_d = ST_ADD0;
         end
         ST_ADD0: begin
            data_d  = data_q ^ round_key;
            round_d = 4'd1;
            state_d = ST_STEP;
         end
         ST_STEP: begin
            settle_d = '0;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            if (last_wait) begin
               data_d  = round_out;
               round_d = round_q + 4'd1;
               state_d = last_round ? ST_DONE : ST_STEP;
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet line
   // up with the state they belong to. out_data loads on entry to DONE and
   // holds afterwards.
   always_comb begin
      in_ready_d  = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      key_start_d = (state_d == ST_KSTART);
      key_step_d  = (state_d == ST_STEP);
      out_valid_d = (state_d == ST_DONE);
      out_data_d  = (state_d == ST_DONE) ? data_d : out_data_q;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign key_start = key_start_q;
   assign key_step  = key_step_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_aes_enc_core.sv
// ---------------------------------------------------------------------------
// tb_aes_enc_core
//
// Two cores: instance 0 with SETTLE=1, instance 1 with SETTLE=3. Each has a
// behavioural key schedule responder. Expected ciphertexts are the FIPS-197
// vectors, queued on acceptance and popped by a monitor on each output
// handshake. The monitor also checks latency, key pulse counts and spacing.
// ---------------------------------------------------------------------------

module tb_aes_enc_core;

   localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid_s  [2];
   logic         in_ready_s  [2];
   logic [127:0] in_data_s   [2];
   logic         out_valid_s [2];
   logic         out_ready_s [2];
   logic [127:0] out_data_s  [2];
   logic         key_start_s [2];
   logic         key_step_s  [2];
   logic [127:0] rk          [2];
   logic         busy_s      [2];

   logic [127:0] base_key [2];
   logic [7:0]   rcon     [2];
   logic         kprev    [2];
   logic [127:0] sbox_row [16];

   logic [127:0] exp_q [2][$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int ks_cnt [2];
   int ke_cnt [2];
   int gap    [2];
   int acc_cyc[2];
   bit first_step[2];
   bit overlap   [2];
   bit prev_step [2];
   bit prev_ov   [2];
   bit acc_valid [2];

   always #5 clk = ~clk;

   aes_enc_core #(.NUM_ROUNDS(10), .SETTLE(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_s[0]),
      .in_ready  (in_ready_s[0]),
      .in_data   (in_data_s[0]),
      .out_valid (out_valid_s[0]),
      .out_ready (out_ready_s[0]),
      .out_data  (out_data_s[0]),
      .key_start (key_start_s[0]),
      .key_step  (key_step_s[0]),
      .round_key (rk[0]),
      .busy      (busy_s[0])
   );

   aes_enc_core #(.NUM_ROUNDS(10), .SETTLE(3)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_s[1]),
      .in_ready  (in_ready_s[1]),
      .in_data   (in_data_s[1]),
      .out_valid (out_valid_s[1]),
      .out_ready (out_ready_s[1]),
      .out_data  (out_data_s[1]),
      .key_start (key_start_s[1]),
      .key_step  (key_step_s[1]),
      .round_key (rk[1]),
      .busy      (busy_s[1])
   );

   function automatic logic [7:0] tb_sbox(input logic [7:0] b);
      logic [127:0] row;
      row = sbox_row[b[7:4]];
      return row[8*(15 - int'(b[3:0])) +: 8];
   endfunction

   function automatic logic [7:0] tb_xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
      t  = {tb_sbox(w3[23:16]), tb_sbox(w3[15:8]), tb_sbox(w3[7:0]), tb_sbox(w3[31:24])}
           ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Key schedule responder: restart on key_start, advance on key_step rise
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (key_start_s[i]) begin
            rk[i]   <= base_key[i];
            rcon[i] <= 8'h01;
         end else if (key_step_s[i] && !kprev[i]) begin
            rk[i]   <= next_key(rk[i], rcon[i]);
            rcon[i] <= tb_xt(rcon[i]);
         end
         kprev[i] <= key_step_s[i];
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   task automatic clear_track(input int i);
      ks_cnt[i]     = 0;
      ke_cnt[i]     = 0;
      gap[i]        = 0;
      first_step[i] = 1'b1;
      overlap[i]    = 1'b0;
      acc_valid[i]  = 1'b0;
   endtask

   // Monitor step for one instance, run on every falling edge
   task automatic monitor_step(input int i);
      logic [127:0] e;
      int lat;
      int set;
      lat = (i == 0) ? 23 : 43;
      set = (i == 0) ? 1 : 3;
      if (rst) begin
         clear_track(i);
         prev_step[i] = 1'b0;
         prev_ov[i]   = 1'b0;
         return;
      end
      if (key_start_s[i]) ks_cnt[i]++;
      if (key_start_s[i] && key_step_s[i]) overlap[i] = 1'b1;
      if (key_step_s[i] && !prev_step[i]) begin
         ke_cnt[i]++;
         if (!first_step[i]) checkOutput($sformatf("step_gap%0d", i), 128'(gap[i]), 128'(set));
         first_step[i] = 1'b0;
         gap[i] = 0;
      end else if (!key_step_s[i]) begin
         gap[i]++;
      end
      prev_step[i] = key_step_s[i];
      if (in_valid_s[i] && in_ready_s[i]) begin
         acc_cyc[i]   = cyc;
         acc_valid[i] = 1'b1;
      end
      if (out_valid_s[i] && !prev_ov[i] && acc_valid[i])
         checkOutput($sformatf("latency%0d", i), 128'(cyc - acc_cyc[i]), 128'(lat));
      prev_ov[i] = out_valid_s[i];
      if (out_valid_s[i] && out_ready_s[i]) begin
         if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output%0d: got %h, expected no output", i, out_data_s[i]);
         end else begin
            e = exp_q[i].pop_front();
            checkOutput($sformatf("ciphertext%0d", i), out_data_s[i], e);
            checkOutput($sformatf("key_start_count%0d", i), 128'(ks_cnt[i]), 128'(1));
            checkOutput($sformatf("key_step_edges%0d", i), 128'(ke_cnt[i]), 128'(10));
            checkOutput($sformatf("start_step_overlap%0d", i), 128'(overlap[i]), 128'(0));
         end
         clear_track(i);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++) monitor_step(i);
   end

   // Offer one block and queue its expected ciphertext when it is accepted
   task automatic applyStimulus(input int i, input logic [127:0] key,
                                input logic [127:0] pt, input logic [127:0] ct);
      bit acc;
      acc = 1'b0;
      base_key[i]   = key;
      in_data_s[i]  = pt;
      in_valid_s[i] = 1'b1;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         if (in_ready_s[i]) begin
            exp_q[i].push_back(ct);
            acc = 1'b1;
         end
      end
      @(posedge clk); #1;
      in_valid_s[i] = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout%0d: got no accept, expected accept", i);
      end
   endtask

   task automatic drain(input int i);
      for (int n = 0; n < 400 && exp_q[i].size() != 0; n++) begin
         @(posedge clk); #1;
      end
      if (exp_q[i].size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL output_timeout%0d: got %0d pending, expected 0", i, exp_q[i].size());
         exp_q[i].delete();
      end
   endtask

   initial begin
      sbox_row[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
      sbox_row[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      sbox_row[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      sbox_row[3]  = 128'h04c723c31896059a071280e2eb27b275;
      sbox_row[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      sbox_row[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      sbox_row[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
      sbox_row[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      sbox_row[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      sbox_row[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
      sbox_row[10] = 128'he0323a0a4906245cc2d3ac629195e479;
      sbox_row[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      sbox_row[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      sbox_row[13] = 128'h703eb5664803f60e613557b986c11d9e;
      sbox_row[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
      sbox_row[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;
      for (int i = 0; i < 2; i++) begin
         in_valid_s[i]  = 1'b0;
         in_data_s[i]   = '0;
         out_ready_s[i] = 1'b1;
         base_key[i]    = '0;
         clear_track(i);
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset values
      @(negedge clk);
      checkOutput("rst_in_ready",  128'(in_ready_s[0]),  128'(1));
      checkOutput("rst_out_valid", 128'(out_valid_s[0]), 128'(0));
      checkOutput("rst_out_data",  out_data_s[0],        128'h0);
      checkOutput("rst_key_start", 128'(key_start_s[0]), 128'(0));
      checkOutput("rst_key_step",  128'(key_step_s[0]),  128'(0));
      checkOutput("rst_busy",      128'(busy_s[0]),      128'(0));
      @(posedge clk); #1;

      $display("[TB] FIPS-197 appendix B vector");
      applyStimulus(0, KEY1, PT1, CT1);
      drain(0);

      $display("[TB] FIPS-197 appendix C.1 vector");
      applyStimulus(0, KEY2, PT2, CT2);
      drain(0);

      $display("[TB] two back-to-back blocks, same key");
      applyStimulus(0, KEY2, PT2, CT2);
      applyStimulus(0, KEY2, PT2, CT2);
      drain(0);

      $display("[TB] output backpressure");
      out_ready_s[0] = 1'b0;
      applyStimulus(0, KEY1, PT1, CT1);
      for (int n = 0; n < 100 && !out_valid_s[0]; n++) @(negedge clk);
      for (int j = 0; j < 5; j++) begin
         checkOutput($sformatf("hold_valid%0d", j), 128'(out_valid_s[0]), 128'(1));
         checkOutput($sformatf("hold_data%0d", j),  out_data_s[0],        CT1);
         checkOutput($sformatf("hold_in_ready%0d", j), 128'(in_ready_s[0]), 128'(0));
         @(posedge clk); #1;
         in_valid_s[0] = (j % 2 == 0);
         in_data_s[0]  = PT2;
         @(negedge clk);
      end
      @(posedge clk); #1;
      in_valid_s[0]  = 1'b0;
      out_ready_s[0] = 1'b1;
      drain(0);

      $display("[TB] reset mid-operation");
      applyStimulus(0, KEY1, PT1, CT1);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      void'(exp_q[0].pop_back());
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_out_valid", 128'(out_valid_s[0]), 128'(0));
      checkOutput("midrst_key_step",  128'(key_step_s[0]),  128'(0));
      checkOutput("midrst_in_ready",  128'(in_ready_s[0]),  128'(1));
      checkOutput("midrst_busy",      128'(busy_s[0]),      128'(0));
      @(posedge clk); #1;
      applyStimulus(0, KEY1, PT1, CT1);
      drain(0);

      $display("[TB] SETTLE=3 instance");
      applyStimulus(1, KEY1, PT1, CT1);
      drain(1);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
